// File: rtl/rv_lsu.sv
// RV32I load/store unit: word-access initiator with sub-word store read-modify-write.
// Optional address range check enabled by defining RV_LSU_BOUNDS_CHECK_EN.
module rv_lsu #(
  parameter int DMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] dmem_addr_o,
  output logic        dmem_wr_o,
  output logic [31:0] dmem_wr_data_o,
  input  logic [31:0] dmem_data_i
);
  localparam int IDX_W = $clog2(DMEM_DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;
  state_t state, state_nxt;

  logic             store_q;
  logic [2:0]       funct3_q;
  logic [IDX_W+1:0] addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      merge_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic [IDX_W-1:0] idx_hold_q;
  logic             accept;
  logic             req_legal;
  logic             is_sw;
  logic [IDX_W-1:0] idx_cur;

  function automatic logic legal_f(input logic st, input logic [2:0] f3, input logic [1:0] lo);
    logic ok;
    ok = st ? (f3 inside {3'b000, 3'b001, 3'b010})
            : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    if (f3[1:0] == 2'b01 && lo[0]) ok = 1'b0;
    if (f3[1:0] == 2'b10 && lo != 2'b00) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lo,
                                           input logic [2:0] f3);
    logic [31:0] sh;
    sh = word >> {lo, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lo,
                                              input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    r = word;
    if (f3[0] == 1'b0) r[{lo, 3'b000} +: 8] = wd[7:0];
    else               r[{lo[1], 4'b0000} +: 16] = wd[15:0];
    return r;
  endfunction

`ifdef RV_LSU_BOUNDS_CHECK_EN
  assign req_legal = legal_f(req_store_i, req_funct3_i, req_addr_i[1:0]) &&
                     (req_addr_i[31:IDX_W+2] == '0);
`else
  // Upper address bits are intentionally dropped, so addresses alias.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[31:IDX_W+2];
  assign req_legal = legal_f(req_store_i, req_funct3_i, req_addr_i[1:0]);
`endif

  assign accept  = req_valid_i && req_ready_o;
  assign is_sw   = store_q && (funct3_q[1:0] == 2'b10);
  assign idx_cur = addr_q[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_legal ? ACCESS : RESP;
      ACCESS:  state_nxt = (store_q && !is_sw) ? MERGE : RESP;
      MERGE:   state_nxt = RESP;
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o    = reset_n && (state == IDLE);
    rsp_valid_o    = (state == RESP);
    dmem_wr_o      = reset_n && (((state == ACCESS) && is_sw) || (state == MERGE));
    dmem_wr_data_o = 32'h0;
    if (state == MERGE)                dmem_wr_data_o = merge_q;
    else if (state == ACCESS && is_sw) dmem_wr_data_o = wdata_q;
    dmem_addr_o = {{(32 - IDX_W){1'b0}},
                   ((state == ACCESS) || (state == MERGE)) ? idx_cur : idx_hold_q};
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      store_q    <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      merge_q    <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      idx_hold_q <= '0;
    end else begin
      // Request capture: errors go straight to the response with zero data.
      if (accept) begin
        store_q  <= req_store_i;
        funct3_q <= req_funct3_i;
        addr_q   <= req_addr_i[IDX_W+1:0];
        wdata_q  <= req_wdata_i;
        err_q    <= !req_legal;
        rdata_q  <= 32'h0;
      end
      // Access stage: memory read data is consumed the same cycle it is addressed.
      if (state == ACCESS) begin
        idx_hold_q <= idx_cur;
        if (!store_q) rdata_q <= load_ext(dmem_data_i, addr_q[1:0], funct3_q);
        merge_q <= store_merge(dmem_data_i, addr_q[1:0], funct3_q, wdata_q);
      end
    end
  end
endmodule

// File: tb/tb_rv_lsu.sv
// Scoreboard bench for rv_lsu: directed test-plan cases then randomized traffic
// against an arithmetic reference model of the data memory.
module tb_rv_lsu;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_store_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'b000;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] dmem_addr_o;
  logic        dmem_wr_o;
  logic [31:0] dmem_wr_data_o;
  logic [31:0] dmem_data_i;

  rv_lsu #(.DMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .dmem_addr_o(dmem_addr_o), .dmem_wr_o(dmem_wr_o),
    .dmem_wr_data_o(dmem_wr_data_o), .dmem_data_i(dmem_data_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          t;
    int          lat;
    int          nwr;
    int          wlat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          rand_mode = 1'b0;
  bit          ready_force = 1'b1;

  assign dmem_data_i = mem[dmem_addr_o[9:0]];

  function automatic logic [31:0] init_word(input int i);
    if (i == 1) return 32'h8899AABB;
    if (i == 2) return 32'h11223344;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte-addressed memory semantics from the ISA rules.
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output exp_t e);
    int          sz, idx, sh;
    bit          legal;
    logic [31:0] mask, v;
    sz    = 1 << f3[1:0];
    legal = st ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    if (a % sz != 0) legal = 1'b0;
`ifdef RV_LSU_BOUNDS_CHECK_EN
    if (a >= 4 * DEPTH) legal = 1'b0;
`endif
    idx    = int'((a / 4) % DEPTH);
    sh     = 8 * int'(a % 4);
    mask   = (sz >= 4) ? 32'hFFFFFFFF : 32'((64'd1 << (8 * sz)) - 1);
    e.err  = !legal;
    e.rdata = 32'h0;
    e.nwr  = 0;
    e.lat  = !legal ? 1 : ((st && sz < 4) ? 3 : 2);
    e.wlat = (sz < 4) ? 2 : 1;
    e.t    = 0;
    if (legal && st) begin
      ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
      e.nwr = 1;
    end else if (legal) begin
      v = (ref_mem[idx] >> sh) & mask;
      if (f3 < 4 && sz < 4 && v[8*sz-1]) v = v | ~mask;
      e.rdata = v;
    end
  endfunction

  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit track);
    int   g = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready_o && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready_o) begin
      check("req_ready_timeout", {31'h0, req_ready_o}, 32'h1);
      return;
    end
    req_valid_i  = 1'b1;
    req_store_i  = st;
    req_funct3_i = f3;
    req_addr_i   = a;
    req_wdata_i  = wd;
    if (track) begin
      model(st, f3, a, wd, e);
      e.t = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("drain", 32'(sb.size()), 32'h0);
    @(negedge clk);
  endtask

  // Memory environment: combinational read, whole-word write.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (dmem_wr_o) mem[dmem_addr_o[9:0]] = dmem_wr_data_o;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    rsp_ready_i = rand_mode ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Monitor: pops the scoreboard on every response handshake.
  initial begin
    bit          prev_v = 1'b0;
    logic [31:0] prev_rdata = 32'h0;
    logic        prev_err = 1'b0;
    int          wr_seen = 0, last_wr = 0, rise = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check("rst_no_wr", {31'h0, dmem_wr_o}, 32'h0);
        check("rst_no_ready", {31'h0, req_ready_o}, 32'h0);
        wr_seen = 0;
        prev_v  = 1'b0;
      end else begin
        if (dmem_wr_o) begin
          wr_seen++;
          last_wr = cyc;
        end
        if (rsp_valid_o && !prev_v) rise = cyc;
        if (rsp_valid_o && prev_v) begin
          check("hold_rdata", rsp_rdata_o, prev_rdata);
          check("hold_err", {31'h0, rsp_err_o}, {31'h0, prev_err});
        end
        if (rsp_valid_o && rsp_ready_i) begin
          if (sb.size() == 0) begin
            check("unexpected_rsp", {31'h0, rsp_valid_o}, 32'h0);
          end else begin
            e = sb.pop_front();
            check("rsp_err", {31'h0, rsp_err_o}, {31'h0, e.err});
            check("rsp_rdata", rsp_rdata_o, e.rdata);
            check("rsp_latency", 32'(rise - e.t), 32'(e.lat));
            check("write_count", 32'(wr_seen), 32'(e.nwr));
            if (e.nwr > 0) check("write_cycle", 32'(last_wr - e.t), 32'(e.wlat));
          end
          check("hs_no_accept", {31'h0, req_ready_o}, 32'h0);
          wr_seen = 0;
        end
        prev_v     = rsp_valid_o;
        prev_rdata = rsp_rdata_o;
        prev_err   = rsp_err_o;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          g;
    int          mism;
    logic [31:0] a, orig;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

    repeat (3) @(negedge clk);
    check("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err_o}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    check("rst_dmem_addr", dmem_addr_o, 32'h0);
    check("rst_dmem_wr_data", dmem_wr_data_o, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'h0, req_ready_o}, 32'h1);

    issue(1'b0, 3'b000, 32'h5, 32'h0, 1'b1);
    issue(1'b0, 3'b100, 32'h5, 32'h0, 1'b1);
    issue(1'b1, 3'b000, 32'hA, 32'h000000EE, 1'b1);
    issue(1'b1, 3'b001, 32'h3, 32'h0000BEEF, 1'b1);
    drain();
    check("sb_mem2", mem[2], 32'h11EE3344);

    ready_force = 1'b0;
    @(negedge clk);
    issue(1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 1'b1);
    g = 0;
    while (!rsp_valid_o && g < 20) begin
      @(negedge clk);
      g++;
    end
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", {31'h0, rsp_valid_o}, 32'h1);
      check("bp_ready", {31'h0, req_ready_o}, 32'h0);
      @(negedge clk);
    end
    ready_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_ready_after", {31'h0, req_ready_o}, 32'h1);
    check("sw_mem4", mem[4], 32'hCAFEF00D);

    orig = mem[6];
    issue(1'b1, 3'b000, 32'h19, 32'h00000077, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rmw_rst_valid", {31'h0, rsp_valid_o}, 32'h0);
    check("rmw_rst_ready", {31'h0, req_ready_o}, 32'h1);
    check("rmw_rst_mem6", mem[6], orig);

    issue(1'b0, 3'b010, 32'h1000, 32'h0, 1'b1);
    drain();

    rand_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFFF000);
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b1);
    end
    rand_mode = 1'b0;
    drain();

    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("mem_final", 32'(mism), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
